store_narrower: RTL and testbench
=================================

STORE_NARROWER -- requirements
Module: store_narrower

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max wait cycles for mem_ready before abort (range 1..255).
REQ-002 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  core presents a store.
REQ-005 SHALL have port req_ready  output  1  block can accept a store.
REQ-006 SHALL have port req_addr  input  32  byte address.
REQ-007 SHALL have port req_data  input  32  register value, to be narrowed.
REQ-008 SHALL have port req_size  input  2  00 byte (SB), 01 half (SH), 10 word (SW), 11 reserved.
REQ-009 SHALL have port mem_valid  output  1  write request to data memory.
REQ-010 SHALL have port mem_ready  input  1  memory accepts the write.
REQ-011 SHALL have port mem_addr  output  32  word-aligned address, {req_addr[31:2],2'b00}.
REQ-012 SHALL have port mem_wdata  output  32  lane-replicated write data.
REQ-013 SHALL have port mem_be  output  4  byte enables; bit i covers mem_wdata[8i+7:8i].
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port err_misalign  output  1  valid with done; store rejected for alignment or reserved size.
REQ-016 SHALL have port err_timeout  output  1  valid with done; memory did not respond.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> DONE -> IDLE, with ERR replacing ISSUE on rejection.
REQ-018 SHALL drive req_ready=1 only in IDLE; acceptance = req_valid && req_ready; inputs captured on that edge.
REQ-019 SHALL encode lanes little-endian: byte be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}; half be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}; word be=4'b1111, wdata=data.
REQ-020 SHALL assert mem_valid the cycle after acceptance and hold mem_valid/mem_addr/mem_wdata/mem_be stable until mem_ready sampled high.
REQ-021 SHALL, on the mem_ready edge, drop mem_valid and pulse done (errors 0) in the next cycle, returning to IDLE the cycle after.
REQ-022 SHALL count wait cycles in ISSUE from 1; if count reaches TIMEOUT_CYCLES with mem_ready low, drop mem_valid, pulse done with err_timeout=1.
REQ-023 SHALL treat mem_ready high in the same cycle the counter hits the limit as success (no timeout).
REQ-024 SHALL ignore mem_ready outside ISSUE; SHALL ignore req_valid outside IDLE (no queueing).
REQ-025 SHALL reject req_size=11 via ERR: no mem_valid, done+err_misalign the cycle after acceptance.
REQ-026 SHALL have minimum store latency 2 cycles (accept -> done) with zero-wait memory; throughput one store per 3 cycles.

Reset
REQ-027 SHALL, on clock edge with reset_n=0, enter IDLE and clear counter; outputs: req_ready=0 during reset, 1 after; mem_valid, done, err_* = 0; mem_addr, mem_wdata, mem_be = 0.
REQ-028 SHALL abort any in-flight ISSUE on reset mid-operation without a done pulse.

Configuration
REQ-029 SHALL, with STORE_MISALIGN_TRAP_EN defined, reject half with addr[0]=1 and word with addr[1:0]!=0 via ERR (done+err_misalign, no memory write).
REQ-030 SHALL, without STORE_MISALIGN_TRAP_EN, force alignment (half uses addr[1], word ignores addr[1:0]), write normally, and tie err_misalign to the reserved-size case only.

Structure
REQ-031 SHALL place size codes, FSM state encoding and TIMEOUT width constant in shared package mips_mem_pkg.
REQ-032 SHALL implement lane/enable encoding as combinational sub-module store_lane_encoder (size, addr[1:0], data -> be, wdata).

Verification
REQ-033 SB addr 0x1003, data 0xAABBCC5A, mem_ready immediate -> mem_addr 0x1000, be 1000, wdata 0x5A5A5A5A, done 2 cycles after accept, errs 0.
REQ-034 SH addr 0x2002, data 0x1234BEEF -> be 1100, wdata 0xBEEFBEEF; SW addr 0x2004 data 0xDEADBEEF -> be 1111, wdata 0xDEADBEEF.
REQ-035 SW addr 0x3001: with macro -> no mem_valid, done+err_misalign; without -> mem_addr 0x3000, be 1111, errs 0.
REQ-036 mem_ready held low, TIMEOUT_CYCLES=4 -> mem_valid high exactly 4 cycles, then done+err_timeout; mem_ready on 4th cycle -> success.
REQ-037 reset_n low during ISSUE -> next cycle mem_valid=0, no done; req_size=11 -> done+err_misalign, no memory write.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the store path: access-size codes, store FSM states
// and the width of the memory wait counter.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERR   = 2'b11
    } state_e;

    // Wide enough for any TIMEOUT_CYCLES in 1..255.
    localparam int TMO_W = 8;

endpackage

// File: rtl/store_lane_encoder.sv
// Little-endian lane steering for stores: replicates the narrowed register
// value across the word and selects the byte enables for the target lanes.
module store_lane_encoder
    import mips_mem_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{data_i[7:0]}};
            end
            SZ_HALF: begin
                // addr[0] is deliberately ignored: halves always land on a half boundary.
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{data_i[15:0]}};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = data_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/store_narrower.sv
// Narrows SB/SH/SW stores onto a 32-bit memory write port with timeout.
// Define STORE_MISALIGN_TRAP_EN to reject misaligned half/word stores.
module store_narrower
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        done,
    output logic        err_misalign,
    output logic        err_timeout
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic               tmo_q, tmo_d;
    logic [31:0]        addr_q, wdata_q;
    logic [3:0]         be_q;
    logic [3:0]         enc_be;
    logic [31:0]        enc_wdata;
    logic               accept;
    logic               reject;
    size_e              size_in;

    assign size_in = size_e'(req_size);

    store_lane_encoder u_enc (
        .size_i    (size_in),
        .addr_lo_i (req_addr[1:0]),
        .data_i    (req_data),
        .be_o      (enc_be),
        .wdata_o   (enc_wdata)
    );

    always_comb begin
        reject = (size_in == SZ_RSVD);
`ifdef STORE_MISALIGN_TRAP_EN
        if (size_in == SZ_HALF && req_addr[0])
            reject = 1'b1;
        if (size_in == SZ_WORD && req_addr[1:0] != 2'b00)
            reject = 1'b1;
`endif
    end

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = reject ? ST_ERR : ST_ISSUE;
                    cnt_d   = TMO_W'(1);
                    tmo_d   = 1'b0;
                end
            end
            ST_ISSUE: begin
                // A late mem_ready on the limit cycle still wins over the timeout.
                if (mem_ready) begin
                    state_d = ST_DONE;
                end else if (cnt_q == TMO_LIMIT) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            if (accept && !reject) begin
                addr_q  <= {req_addr[31:2], 2'b00};
                wdata_q <= enc_wdata;
                be_q    <= enc_be;
            end
        end
    end

    assign req_ready    = (state_q == ST_IDLE) && reset_n;
    assign mem_valid    = (state_q == ST_ISSUE);
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_be       = be_q;
    assign done         = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign err_misalign = (state_q == ST_ERR);
    assign err_timeout  = (state_q == ST_DONE) && tmo_q;

endmodule

// File: tb/tb_store_narrower.sv
// Randomized self-checking bench for store_narrower against a lane/latency model.
module tb_store_narrower;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err_misalign;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    store_narrower #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_size     (req_size),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .done         (done),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_reject(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
        if (sz == 2'b01 && a[0]) return 1'b1;
        if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        int sh;
        case (sz)
            2'b00: begin sh = int'(a[1:0]);  return 4'(1 << sh); end
            2'b01: begin sh = 2 * int'(a[1]); return 4'(3 << sh); end
            2'b10: return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00: return 32'(d[7:0]) * 32'h0101_0101;
            2'b01: return 32'(d[15:0]) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // rdy_at: mem_valid cycle (1-based) on which memory accepts; 0 means never.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input int rdy_at);
        int   nvalid   = 0;
        int   done_cyc = 0;
        int   exp_cyc, exp_nvalid;
        logic em = 1'b0, et = 1'b0;
        logic exp_em, exp_et;
        bit   rej;
        rej = exp_reject(sz, a);
        if (rej) begin
            exp_cyc = 1; exp_nvalid = 0; exp_em = 1'b1; exp_et = 1'b0;
        end else if (rdy_at >= 1 && rdy_at <= TMO) begin
            exp_cyc = rdy_at + 1; exp_nvalid = rdy_at; exp_em = 1'b0; exp_et = 1'b0;
        end else begin
            exp_cyc = TMO + 1; exp_nvalid = TMO; exp_em = 1'b0; exp_et = 1'b1;
        end

        @(negedge clock);
        check_eq("ready_idle", req_ready, 1'b1);
        check_eq("done_idle", done, 1'b0);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        for (int cyc = 1; cyc <= TMO + 6; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                req_addr = $urandom;
                req_data = $urandom;
                req_size = 2'($urandom);
            end
            check_eq("ready_busy", req_ready, 1'b0);
            if (mem_valid) begin
                nvalid++;
                check_eq("mem_addr", mem_addr, {a[31:2], 2'b00});
                check_eq("mem_be", mem_be, exp_be(sz, a));
                check_eq("mem_wdata", mem_wdata, exp_wdata(sz, d));
                mem_ready = (nvalid == rdy_at);
            end else begin
                mem_ready = 1'($urandom);
            end
            if (done) begin
                done_cyc = cyc;
                em = err_misalign;
                et = err_timeout;
                break;
            end
            req_valid = 1'($urandom);
        end
        req_valid = 1'b0;
        mem_ready = 1'b0;
        check_eq("done_cycle", done_cyc, exp_cyc);
        check_eq("valid_cycles", nvalid, exp_nvalid);
        check_eq("err_misalign", em, exp_em);
        check_eq("err_timeout", et, exp_et);
        $display("TXN size=%0d addr=0x%08h data=0x%08h rdy_at=%0d done_cyc=%0d valid_cycles=%0d misalign=%0b timeout=%0b",
                 sz, a, d, rdy_at, done_cyc, nvalid, em, et);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        req_size  = 2'b00;
        mem_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_ready", req_ready, 1'b0);
        check_eq("rst_valid", mem_valid, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_errs", {err_misalign, err_timeout}, 2'b00);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_wdata", mem_wdata, 32'h0);
        check_eq("rst_be", mem_be, 4'h0);
        reset_n = 1'b1;

        run_store(32'h0000_1003, 32'hAABB_CC5A, 2'b00, 1);
        run_store(32'h0000_2002, 32'h1234_BEEF, 2'b01, 1);
        run_store(32'h0000_2004, 32'hDEAD_BEEF, 2'b10, 1);
        run_store(32'h0000_3001, 32'hCAFE_F00D, 2'b10, 1);
        run_store(32'h0000_4001, 32'h0000_7788, 2'b01, 2);
        run_store(32'h0000_5000, 32'h1111_2222, 2'b10, 0);
        run_store(32'h0000_5004, 32'h3333_4444, 2'b10, TMO);
        run_store(32'h0000_6000, 32'h5555_6666, 2'b11, 1);

        // Reset while a store is waiting on memory: it must vanish without done.
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = 32'h0000_7000;
        req_data  = 32'h0BAD_F00D;
        req_size  = 2'b10;
        @(negedge clock);
        req_valid = 1'b0;
        check_eq("abort_valid1", mem_valid, 1'b1);
        @(negedge clock);
        check_eq("abort_valid2", mem_valid, 1'b1);
        reset_n = 1'b0;
        @(negedge clock);
        check_eq("abort_valid_rst", mem_valid, 1'b0);
        check_eq("abort_done_rst", done, 1'b0);
        check_eq("abort_ready_rst", req_ready, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("abort_no_done", done, 1'b0);
            check_eq("abort_no_valid", mem_valid, 1'b0);
        end
        $display("TXN reset-abort addr=0x00007000");

        for (int n = 0; n < 40; n++) begin
            run_store($urandom, $urandom, 2'($urandom), int'($urandom_range(0, TMO + 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
